// File: rtl/game_pkg.sv
// Shared constants for the game input path: PS/2 prefix bytes, default
// key scancodes and the bit layout of the held-key vector.
package game_pkg;

   // PS/2 set-2 prefix and status bytes
   localparam logic [7:0] SC_EXT      = 8'hE0;
   localparam logic [7:0] SC_BREAK    = 8'hF0;
   localparam logic [7:0] SC_SELFTEST = 8'hAA;

   // Default key scancodes
   localparam logic [7:0] SC_P1_LEFT  = 8'h1C;  // A
   localparam logic [7:0] SC_P1_RIGHT = 8'h23;  // D
   localparam logic [7:0] SC_P1_JUMP  = 8'h1D;  // W
   localparam logic [7:0] SC_P2_LEFT  = 8'h6B;  // E0 + arrow left
   localparam logic [7:0] SC_P2_RIGHT = 8'h74;  // E0 + arrow right
   localparam logic [7:0] SC_P2_JUMP  = 8'h75;  // E0 + arrow up
   localparam logic [7:0] SC_RESET    = 8'h2D;  // R

   // Held-key vector layout
   localparam int KEY_W       = 7;
   localparam int K_P1_LEFT   = 6;
   localparam int K_P1_RIGHT  = 5;
   localparam int K_P1_JUMP   = 4;
   localparam int K_P2_LEFT   = 3;
   localparam int K_P2_RIGHT  = 2;
   localparam int K_P2_JUMP   = 1;
   localparam int K_RESET     = 0;

endpackage

// File: rtl/player_key_decoder.sv
// Turns the PS/2 scancode byte stream into held-key levels for both players
// and the game-reset key. A small FSM tracks E0/F0 prefixes; a prefix that
// is never completed is abandoned after TIMEOUT_CYCLES so a lost byte cannot
// leave the decoder stuck in a prefix state.
module player_key_decoder
   import game_pkg::*;
#(
   parameter int         TIMEOUT_CYCLES = 1_300_000,
   parameter logic [7:0] P1_LEFT_CODE   = SC_P1_LEFT,
   parameter logic [7:0] P1_RIGHT_CODE  = SC_P1_RIGHT,
   parameter logic [7:0] P1_JUMP_CODE   = SC_P1_JUMP,
   parameter logic [7:0] P2_LEFT_CODE   = SC_P2_LEFT,
   parameter logic [7:0] P2_RIGHT_CODE  = SC_P2_RIGHT,
   parameter logic [7:0] P2_JUMP_CODE   = SC_P2_JUMP,
   parameter logic [7:0] RESET_CODE     = SC_RESET
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       p1_left,
   output logic       p1_right,
   output logic       p1_jump,
   output logic       p2_left,
   output logic       p2_right,
   output logic       p2_jump,
   output logic       game_reset
);

   localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES);
   localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXT     = 2'd1,
      BRK     = 2'd2,
      EXT_BRK = 2'd3
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [KEY_W-1:0]   keys_q;
   logic [KEY_W-1:0]   norm_mask_s;
   logic [KEY_W-1:0]   ext_mask_s;

   // Key bit selected by the current byte when read as a non-extended code
   always_comb begin
      norm_mask_s = {KEY_W{1'b0}};
      if (rx_data == P1_LEFT_CODE) begin
         norm_mask_s[K_P1_LEFT] = 1'b1;
      end else if (rx_data == P1_RIGHT_CODE) begin
         norm_mask_s[K_P1_RIGHT] = 1'b1;
      end else if (rx_data == P1_JUMP_CODE) begin
         norm_mask_s[K_P1_JUMP] = 1'b1;
      end else if (rx_data == RESET_CODE) begin
         norm_mask_s[K_RESET] = 1'b1;
      end else begin
         norm_mask_s = {KEY_W{1'b0}};
      end
   end

   // Key bit selected by the current byte when read as an E0-extended code
   always_comb begin
      ext_mask_s = {KEY_W{1'b0}};
      if (rx_data == P2_LEFT_CODE) begin
         ext_mask_s[K_P2_LEFT] = 1'b1;
      end else if (rx_data == P2_RIGHT_CODE) begin
         ext_mask_s[K_P2_RIGHT] = 1'b1;
      end else if (rx_data == P2_JUMP_CODE) begin
         ext_mask_s[K_P2_JUMP] = 1'b1;
      end else begin
         ext_mask_s = {KEY_W{1'b0}};
      end
   end

   // Prefix FSM, prefix timeout counter and registered held-key levels
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         keys_q  <= {KEY_W{1'b0}};
      end else if (rx_valid) begin
         // A byte always wins over an expiring timeout
         cnt_q <= {CNT_W{1'b0}};
         case (state_q)
            IDLE: begin
               if (rx_data == SC_EXT) begin
                  state_q <= EXT;
               end else if (rx_data == SC_BREAK) begin
                  state_q <= BRK;
               end else if (rx_data == SC_SELFTEST) begin
                  keys_q <= {KEY_W{1'b0}};
               end else begin
                  keys_q <= keys_q | norm_mask_s;
               end
            end
            EXT: begin
               if (rx_data == SC_BREAK) begin
                  state_q <= EXT_BRK;
               end else begin
                  keys_q  <= keys_q | ext_mask_s;
                  state_q <= IDLE;
               end
            end
            BRK: begin
               keys_q  <= keys_q & ~norm_mask_s;
               state_q <= IDLE;
            end
            EXT_BRK: begin
               keys_q  <= keys_q & ~ext_mask_s;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end else if (state_q != IDLE) begin
         // Waiting for the completing byte of a prefix
         if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
         end else begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end else begin
         cnt_q <= {CNT_W{1'b0}};
      end
   end

   assign p1_left    = keys_q[K_P1_LEFT];
   assign p1_right   = keys_q[K_P1_RIGHT];
   assign p1_jump    = keys_q[K_P1_JUMP];
   assign p2_left    = keys_q[K_P2_LEFT];
   assign p2_right   = keys_q[K_P2_RIGHT];
   assign p2_jump    = keys_q[K_P2_JUMP];
   assign game_reset = keys_q[K_RESET];

endmodule

// File: tb/tb_player_key_decoder.sv
// Directed bench for player_key_decoder: a table of {byte, expected held keys}
// records applied in order, plus hand sequences for timeout and reset cases.
// Expected vector bit order: p1_left p1_right p1_jump p2_left p2_right p2_jump game_reset
module tb_player_key_decoder;

   localparam int T = 16;

   logic       clk;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       p1_left, p1_right, p1_jump;
   logic       p2_left, p2_right, p2_jump;
   logic       game_reset;

   int n_vec;
   int n_err;

   typedef struct {
      logic [7:0] data;
      logic [6:0] exp;
   } vec_t;

   vec_t tbl[$];

   player_key_decoder #(.TIMEOUT_CYCLES(T)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .p1_left    (p1_left),
      .p1_right   (p1_right),
      .p1_jump    (p1_jump),
      .p2_left    (p2_left),
      .p2_right   (p2_right),
      .p2_jump    (p2_jump),
      .game_reset (game_reset)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] outs();
      return {p1_left, p1_right, p1_jump, p2_left, p2_right, p2_jump, game_reset};
   endfunction

   task automatic check(input string name, input logic [6:0] exp);
      logic [6:0] got;
      got = outs();
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: outputs got %b, expected %b", name, got, exp);
      end
   endtask

   // Called at a negedge; presents the byte for exactly one rising edge and
   // returns at the following negedge, after the outputs have updated.
   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic add(input logic [7:0] d, input logic [6:0] e);
      vec_t v;
      v.data = d;
      v.exp  = e;
      tbl.push_back(v);
   endtask

   initial begin
      n_vec    = 0;
      n_err    = 0;
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;

      // make / break of P1 left
      add(8'h1C, 7'b1000000);
      add(8'hF0, 7'b1000000);
      add(8'h1C, 7'b0000000);
      // extended make / break of P2 jump
      add(8'hE0, 7'b0000000);
      add(8'h75, 7'b0000010);
      add(8'hE0, 7'b0000010);
      add(8'hF0, 7'b0000010);
      add(8'h75, 7'b0000000);
      // cross-space: bare 75, E0 1D
      add(8'h75, 7'b0000000);
      add(8'hE0, 7'b0000000);
      add(8'h1D, 7'b0000000);
      // hold four non-extended keys, typematic repeat, then AA clears
      add(8'h1C, 7'b1000000);
      add(8'h23, 7'b1100000);
      add(8'h1D, 7'b1110000);
      add(8'h2D, 7'b1110001);
      add(8'h1C, 7'b1110001);
      add(8'hAA, 7'b0000000);
      // break of a key not held
      add(8'hF0, 7'b0000000);
      add(8'h23, 7'b0000000);
      // P2 left and right, bare 6B ignored
      add(8'hE0, 7'b0000000);
      add(8'h6B, 7'b0001000);
      add(8'hE0, 7'b0001000);
      add(8'h74, 7'b0001100);
      add(8'h6B, 7'b0001100);
      // unmapped extended byte returns to IDLE
      add(8'hE0, 7'b0001100);
      add(8'h12, 7'b0001100);
      add(8'h1C, 7'b1001100);
      add(8'hF0, 7'b1001100);
      add(8'h1C, 7'b0001100);
      // extended breaks
      add(8'hE0, 7'b0001100);
      add(8'hF0, 7'b0001100);
      add(8'h6B, 7'b0000100);
      add(8'hE0, 7'b0000100);
      add(8'hF0, 7'b0000100);
      add(8'h74, 7'b0000000);
      // pause sequence E1 14 77 E1 F0 14 F0 77
      add(8'hE1, 7'b0000000);
      add(8'h14, 7'b0000000);
      add(8'h77, 7'b0000000);
      add(8'hE1, 7'b0000000);
      add(8'hF0, 7'b0000000);
      add(8'h14, 7'b0000000);
      add(8'hF0, 7'b0000000);
      add(8'h77, 7'b0000000);
      // F0 then E0: E0 is consumed by BRK, so following 74 is bare
      add(8'hF0, 7'b0000000);
      add(8'hE0, 7'b0000000);
      add(8'h74, 7'b0000000);

      idle(3);
      check("reset_state", 7'b0000000);
      rst = 1'b0;
      idle(1);
      check("after_reset", 7'b0000000);

      for (int i = 0; i < tbl.size(); i++) begin
         send(tbl[i].data);
         check($sformatf("vec%0d_%h", i, tbl[i].data), tbl[i].exp);
      end

      // Prefix abandoned after T idle cycles: 6B then decoded as bare
      send(8'hE0);
      idle(T);
      send(8'h6B);
      check("timeout_expired", 7'b0000000);

      // 6B arriving well before expiry (cycle T-2 after the prefix)
      send(8'hE0);
      idle(T - 3);
      send(8'h6B);
      check("timeout_early", 7'b0001000);
      send(8'hE0);
      send(8'hF0);
      send(8'h6B);
      check("release_p2_left", 7'b0000000);

      // 6B arriving exactly in the expiry cycle is still decoded as extended
      send(8'hE0);
      idle(T - 1);
      send(8'h6B);
      check("timeout_expiry_cycle", 7'b0001000);

      // Break prefix after expiry: counter must restart for a new prefix
      send(8'hF0);
      idle(T);
      send(8'h6B);
      check("brk_timeout", 7'b0001000);

      // Reset mid-sequence: clears outputs and discards the F0 prefix
      send(8'h1C);
      send(8'hF0);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      check("rst_clears", 7'b0000000);
      send(8'h23);
      check("rst_discards_brk", 7'b0100000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/player_key_decoder.md
Name: player_key_decoder

Overview:
Converts the PS/2 scancode byte stream from the keyboard receiver into held-key level signals for both players: left, right and jump for each, plus a game-reset key. It feeds player_move_ctrl, driving its left/right/jump/reset inputs directly. It tracks make, break and extended (E0) prefixes with a small FSM, and uses a prefix timeout so that a lost byte cannot corrupt key state.

Parameters:
TIMEOUT_CYCLES, 1_300_000, clk cycles allowed between a prefix byte and its completing byte (about 20 ms at 65 MHz).
P1_LEFT_CODE, 8'h1C, non-extended code for P1 left (A).
P1_RIGHT_CODE, 8'h23, non-extended code for P1 right (D).
P1_JUMP_CODE, 8'h1D, non-extended code for P1 jump (W).
P2_LEFT_CODE, 8'h6B, extended (E0-prefixed) code for P2 left (arrow left).
P2_RIGHT_CODE, 8'h74, extended code for P2 right (arrow right).
P2_JUMP_CODE, 8'h75, extended code for P2 jump (arrow up).
RESET_CODE, 8'h2D, non-extended code for game reset (R).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rx_data  in  8  received scancode byte
rx_valid  in  1  one-cycle strobe, rx_data valid; always accepted, no back-pressure
p1_left  out  1  P1 left key held
p1_right  out  1  P1 right key held
p1_jump  out  1  P1 jump key held
p2_left  out  1  P2 left key held
p2_right  out  1  P2 right key held
p2_jump  out  1  P2 jump key held
game_reset  out  1  reset key held (level)

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset: all outputs 0, FSM in IDLE, timeout counter 0.
- All outputs are registered. A completing byte accepted in cycle N updates its output at the N+1 clock edge. Prefix bytes never change outputs.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
- IDLE:
  - E0 goes to EXT.
  - F0 goes to BRK.
  - AA (keyboard self-test passed) clears all key outputs and stays in IDLE.
  - A matching non-extended code sets its output to 1.
  - Any other byte is ignored and the FSM stays in IDLE.
- EXT:
  - F0 goes to EXT_BRK.
  - A matching extended code sets its output to 1 and returns to IDLE.
  - Any other byte returns to IDLE with no change.
- BRK: a matching non-extended code clears its output to 0. Any byte returns to IDLE.
- EXT_BRK: a matching extended code clears its output to 0. Any byte returns to IDLE.
- Extended and non-extended spaces are separate:
  - E0 1C does not affect p1_left.
  - A bare 6B does not affect p2_left.
- Repeated make codes (typematic) leave the output at 1. A break code for a key not held leaves it at 0.
- Timeout counter:
  - Cleared on every rx_valid and held at 0 in IDLE.
  - Increments each cycle in EXT, BRK or EXT_BRK without rx_valid.
  - At TIMEOUT_CYCLES-1 it forces the FSM to IDLE, clears the counter and leaves outputs unchanged.
  - If rx_valid arrives in the expiry cycle, the byte is processed normally and the timeout is discarded.
- Counter width is $clog2(TIMEOUT_CYCLES) bits, with no wrap.
- E1 (pause) sequences: handled byte-by-byte by the rules above. No mapped code appears in them, so outputs do not change.
- Simultaneous keys: no arbitration here. The left-and-right case is resolved in player_move_ctrl.
- rst mid-sequence (for example after E0) returns to IDLE with outputs 0. The next byte is decoded from IDLE.

Decomposition:
- Scancode constants (E0, F0, AA and the default key codes) go in game_pkg as localparams.
- The FSM state typedef is local to the module.
- No sub-module: the prefix timeout counter stays inline.

Test Plan:
- Reset then 1C: p1_left=1 one cycle after rx_valid; then F0,1C gives p1_left=0; other outputs stay 0 throughout.
- E0,75: p2_jump=1; then E0,F0,75 gives p2_jump=0; p1_jump stays 0 during both sequences.
- Cross-space check: bare 75 leaves p2_jump=0; E0,1D leaves p1_jump=0.
- Hold 1C,23,1D,2D: all four of p1_left, p1_right, p1_jump, game_reset are 1; then AA clears all to 0 the next cycle.
- E0, then idle TIMEOUT_CYCLES cycles, then 6B: p2_left stays 0 (FSM timed out to IDLE). Same with 6B arriving at cycle TIMEOUT_CYCLES-2: p2_left=1.
- Send F0, assert rst for one cycle, then 23: p1_right=1, showing the break prefix was discarded by reset.
